// File: rtl/neuron_update_scheduler.sv
// neuron_update_scheduler
// Buffers weight events in a small FIFO and applies them one at a time to a
// locally held potential array through an external combinational LIF adder.
// A timestep-end request blocks new events, drains the queue and then pulses
// ts_done.
// Optional feature: define NEURON_SPIKE_COUNT_EN to add a saturating 16-bit
// spike_count output that clears on ts_done.
module neuron_update_scheduler #(
    parameter int NUM_NEURONS = 8,
    parameter int ID_W        = 3,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ev_valid,
    input  logic [ID_W-1:0] ev_id,
    input  logic [31:0]     ev_weight,
    output logic            ev_ready,
    input  logic            ts_end,
    output logic            ts_done,
    output logic [31:0]     adder_weight,
    output logic [31:0]     adder_potential,
    input  logic [31:0]     adder_result,
    input  logic            adder_spike,
    output logic            spike_valid,
    output logic [ID_W-1:0] spike_id
`ifdef NEURON_SPIKE_COUNT_EN
    ,
    output logic [15:0]     spike_count
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_C = FIFO_DEPTH[AW:0];
    localparam logic [ID_W:0] NN_C    = NUM_NEURONS[ID_W:0];
    localparam logic [AW:0]   ONE_C   = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Event FIFO: each entry holds {id, weight}
    logic [ID_W+31:0] fifo_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             push, pop, fifo_empty, fifo_full;
    logic [ID_W-1:0]  head_id;
    logic [31:0]      head_w;
    logic             head_ok;

    logic [31:0]      pot_q [NUM_NEURONS];
    logic [31:0]      pot_rd;

    logic [31:0]      aw_q, aw_d, ap_q, ap_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             pend_q, pend_d;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == DEPTH_C);
    // Full blocks the push even if the same cycle pops; pending blocks too.
    assign ev_ready   = !fifo_full && !pend_q;
    assign push       = ev_valid && ev_ready;
    assign pop        = (state_q == LOAD);

    assign head_id = fifo_q[rd_q][ID_W+31:32];
    assign head_w  = fifo_q[rd_q][31:0];
    assign head_ok = ({1'b0, head_id} < NN_C);
    assign pot_rd  = head_ok ? pot_q[head_id] : 32'h0;

    // FIFO storage write (data needs no reset; occupancy is tracked by cnt_q)
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_q] <= {ev_id, ev_weight};
    end

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_d  = push ? wr_q + 1'b1 : wr_q;
        rd_d  = pop  ? rd_q + 1'b1 : rd_q;
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + ONE_C;
            2'b01:   cnt_d = cnt_q - ONE_C;
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO pointer and occupancy registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Potential array: written only in CAPTURE with the adder's result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_NEURONS; i++) pot_q[i] <= 32'h0;
        end else if (state_q == CAPTURE) begin
            pot_q[id_q] <= adder_result;
        end
    end

    // FSM next-state, adder operand capture and pending-flag update
    always_comb begin
        state_d = state_q;
        aw_d    = aw_q;
        ap_d    = ap_q;
        id_d    = id_q;
        pend_d  = pend_q;
        if (ts_end) pend_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (!fifo_empty)  state_d = LOAD;
                else if (pend_q)  state_d = DRAIN;
            end
            LOAD: begin
                if (head_ok) begin
                    aw_d    = head_w;
                    ap_d    = pot_rd;
                    id_d    = head_id;
                    state_d = CAPTURE;
                end else begin
                    // Out-of-range id: dropped after a single LOAD cycle
                    state_d = (cnt_q > ONE_C) ? LOAD : IDLE;
                end
            end
            CAPTURE: state_d = fifo_empty ? IDLE : LOAD;
            DRAIN: begin
                pend_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and operand registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            aw_q    <= 32'h0;
            ap_q    <= 32'h0;
            id_q    <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            aw_q    <= aw_d;
            ap_q    <= ap_d;
            id_q    <= id_d;
            pend_q  <= pend_d;
        end
    end

    assign adder_weight    = aw_q;
    assign adder_potential = ap_q;
    assign ts_done         = (state_q == DRAIN);
    assign spike_valid     = (state_q == CAPTURE) && adder_spike;
    assign spike_id        = spike_valid ? id_q : '0;

`ifdef NEURON_SPIKE_COUNT_EN
    logic [15:0] scnt_q, scnt_d;

    // Saturating spike counter, cleared when the timestep completes
    always_comb begin
        scnt_d = scnt_q;
        if (ts_done)                              scnt_d = 16'h0;
        else if (spike_valid && scnt_q != 16'hFFFF) scnt_d = scnt_q + 16'h1;
    end

    // Spike counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) scnt_q <= 16'h0;
        else       scnt_q <= scnt_d;
    end

    assign spike_count = scnt_q;
`endif

endmodule

// File: tb/tb_neuron_update_scheduler.sv
// Scoreboard bench for neuron_update_scheduler: stimulus pushes expected adder
// operands and spike ids into queues; a negedge monitor pops and compares.
module tb_neuron_update_scheduler;
    localparam int NN = 6;

    logic        clk = 1'b0, reset = 1'b1, ev_valid = 1'b0, ts_end = 1'b0;
    logic [2:0]  ev_id = '0;
    logic [31:0] ev_weight = '0;
    logic        ev_ready, ts_done, adder_spike, spike_valid;
    logic [31:0] adder_weight, adder_potential, adder_result;
    logic [2:0]  spike_id;
`ifdef NEURON_SPIKE_COUNT_EN
    logic [15:0] spike_count;
`endif

    neuron_update_scheduler #(.NUM_NEURONS(NN), .ID_W(3), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .ev_valid(ev_valid), .ev_id(ev_id),
        .ev_weight(ev_weight), .ev_ready(ev_ready), .ts_end(ts_end),
        .ts_done(ts_done), .adder_weight(adder_weight),
        .adder_potential(adder_potential), .adder_result(adder_result),
        .adder_spike(adder_spike), .spike_valid(spike_valid), .spike_id(spike_id)
`ifdef NEURON_SPIKE_COUNT_EN
        , .spike_count(spike_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, cyc = 0, last_cap = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic fail(input string nm);
        n_chk++;
        $display("FAIL %s: got timeout/unexpected expected event", nm);
    endtask

    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        real a;
        int  e;
        logic [22:0] fr;
        if (r == 0.0) return 32'h0;
        a = (r < 0.0) ? -r : r;
        e = 127;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        fr = 23'($rtoi((a - 1.0) * 8388608.0));
        return {(r < 0.0), e[7:0], fr};
    endfunction

    // LIF adder stand-in: threshold 40.0, reset by subtraction
    always_comb begin
        real s;
        s = f2r(adder_potential) + f2r(adder_weight);
        adder_spike  = (s >= 40.0);
        adder_result = r2f(adder_spike ? s - 40.0 : s);
    end

    // Reference model and scoreboard queues
    logic [31:0] mpot [NN];
    logic [63:0] ld_q [$];
    logic [2:0]  sp_q [$];

    function automatic void model_ev(input logic [2:0] id, input logic [31:0] w);
        real s;
        if (int'(id) >= NN) return;
        ld_q.push_back({w, mpot[id]});
        s = f2r(mpot[id]) + f2r(w);
        if (s >= 40.0) begin
            s = s - 40.0;
            sp_q.push_back(id);
        end
        mpot[id] = r2f(s);
    endfunction

    // Monitor: compare adder operands in CAPTURE and every spike pulse
    always @(negedge clk) begin
        if (!reset) begin
            if (dut.state_q == 2'd2) begin
                last_cap <= cyc;
                if (ld_q.size() == 0) fail("load_unexpected");
                else begin
                    logic [63:0] e;
                    e = ld_q.pop_front();
                    chk("load_weight", adder_weight, e[63:32]);
                    chk("load_potential", adder_potential, e[31:0]);
                end
            end
            if (spike_valid) begin
                if (sp_q.size() == 0) fail("spike_unexpected");
                else chk("spike_id", {29'd0, spike_id}, {29'd0, sp_q.pop_front()});
            end
        end
    end

    task automatic push_ev(input logic [2:0] id, input logic [31:0] w, input bit use_model);
        int t;
        t = 0;
        @(negedge clk);
        ev_valid = 1'b1; ev_id = id; ev_weight = w;
        while (!ev_ready && t < 40) begin @(negedge clk); t++; end
        if (!ev_ready) begin
            fail("push_timeout");
            ev_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 ev_valid = 1'b0;
            if (use_model) model_ev(id, w);
        end
    endtask

    task automatic idle_wait();
        repeat (12) @(negedge clk);
    endtask

    task automatic pulse_ts();
        @(negedge clk);
        ts_end = 1'b1;
        @(posedge clk);
        #1 ts_end = 1'b0;
    endtask

    // Wait for ts_done, requiring ev_ready low every cycle until it arrives
    task automatic wait_done(output int at);
        int t;
        t = 0;
        at = -1;
        while (t < 60) begin
            @(negedge clk);
            if (ts_done) begin at = cyc; break; end
            chk("ready_low_pending", {31'd0, ev_ready}, 32'd0);
            t++;
        end
        if (at < 0) fail("ts_done_timeout");
    endtask

    initial begin
        logic [2:0]  bid [8];
        bit          rdy [40];
        int          i, k, at, ndone;
        for (int n = 0; n < NN; n++) mpot[n] = 32'h0;
        bid = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd0, 3'd1, 3'd4, 3'd5};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ts_done", {31'd0, ts_done}, 32'd0);
        chk("rst_spike_valid", {31'd0, spike_valid}, 32'd0);
        chk("rst_spike_id", {29'd0, spike_id}, 32'd0);
        chk("rst_adder_weight", adder_weight, 32'h0);
        chk("rst_adder_potential", adder_potential, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ev_ready", {31'd0, ev_ready}, 32'd1);

        // Neuron 3: 25 + 25 -> spike on the second, residual 10.0; latency N+3
        push_ev(3'd3, 32'h41C80000, 1'b1);
        idle_wait();
        push_ev(3'd3, 32'h41C80000, 1'b1);
        @(negedge clk); chk("lat_n1", {31'd0, spike_valid}, 32'd0);
        @(negedge clk); chk("lat_n2", {31'd0, spike_valid}, 32'd0);
        @(negedge clk); chk("lat_n3", {31'd0, spike_valid}, 32'd1);
        chk("lat_id", {29'd0, spike_id}, 32'd3);
        idle_wait();
        push_ev(3'd3, 32'h0, 1'b1);
        idle_wait();
        chk("pot3_residual", adder_potential, 32'h41200000);

        // Back-to-back to neuron 2: 30 then 15 -> spike, residual 5.0
        push_ev(3'd2, 32'h41F00000, 1'b1);
        push_ev(3'd2, 32'h41700000, 1'b1);
        push_ev(3'd2, 32'h0, 1'b1);
        idle_wait();
        chk("pot2_residual", adder_potential, 32'h40A00000);

        // Burst of 8: full at the 7th offered cycle even though LOAD pops
        i = 0; k = 0;
        while (i < 8 && k < 40) begin
            @(negedge clk);
            ev_valid = 1'b1; ev_id = bid[i]; ev_weight = 32'h41400000;
            rdy[k] = ev_ready;
            @(posedge clk);
            if (rdy[k]) begin model_ev(bid[i], 32'h41400000); i++; end
            k++;
        end
        #1 ev_valid = 1'b0;
        if (i < 8) fail("burst_timeout");
        for (int c = 0; c < 6; c++) chk("burst_ready_pre", {31'd0, rdy[c]}, 32'd1);
        chk("burst_full", {31'd0, rdy[6]}, 32'd0);
        chk("burst_after_pop", {31'd0, rdy[7]}, 32'd1);
        idle_wait();

        // ts_end with 3 events queued (neuron 1: 12,24,36 -> 48 spike)
        push_ev(3'd1, 32'h41400000, 1'b1);
        push_ev(3'd1, 32'h41400000, 1'b1);
        push_ev(3'd1, 32'h41400000, 1'b1);
        pulse_ts();
        pulse_ts();
        wait_done(at);
        chk("ts_done_timing", at, last_cap + 2);
        @(negedge clk);
        chk("ts_done_one_cycle", {31'd0, ts_done}, 32'd0);
        chk("ready_after_done", {31'd0, ev_ready}, 32'd1);
        ndone = 0;
        repeat (10) begin @(negedge clk); if (ts_done) ndone++; end
        chk("no_second_done", ndone, 0);

        // Out-of-range id is dropped; potentials unchanged afterwards
        push_ev(3'd7, 32'h41C80000, 1'b1);
        idle_wait();
        push_ev(3'd1, 32'h0, 1'b1);
        push_ev(3'd3, 32'h0, 1'b1);
        idle_wait();

        // Reset in CAPTURE discards the in-flight spike-producing event
        push_ev(3'd3, 32'h42C80000, 1'b0);
        @(posedge clk); @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_cap_spike", {31'd0, spike_valid}, 32'd0);
        chk("rst_cap_adder_p", adder_potential, 32'h0);
        for (int n = 0; n < NN; n++) mpot[n] = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        push_ev(3'd3, 32'h41200000, 1'b1);
        push_ev(3'd2, 32'h0, 1'b1);
        push_ev(3'd1, 32'h0, 1'b1);
        idle_wait();

`ifdef NEURON_SPIKE_COUNT_EN
        chk("scnt_zero", {16'd0, spike_count}, 32'd0);
        push_ev(3'd0, 32'h42340000, 1'b1);
        idle_wait();
        chk("scnt_one", {16'd0, spike_count}, 32'd1);
        push_ev(3'd0, 32'h42340000, 1'b1);
        idle_wait();
        chk("scnt_two", {16'd0, spike_count}, 32'd2);
        pulse_ts();
        wait_done(at);
        @(negedge clk);
        chk("scnt_cleared", {16'd0, spike_count}, 32'd0);
`endif

        chk("load_queue_drained", ld_q.size(), 0);
        chk("spike_queue_drained", sp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
